// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter
//   Two-requester round-robin arbiter in front of the SPI SRAM master
//   memory port. Requester 0 is the CPU side, requester 1 the DMA/debug
//   port. One transaction at a time; the granted requester's command is
//   passed combinationally to the memory port while BUSY.
//
//   Optional feature macro: SPI_ARB_BURST_EN
//     When defined, a granted requester that presents the next sequential
//     address (same direction) in the cycle its access completes keeps the
//     grant, with mem_en held high, for up to MAX_BURST back-to-back
//     accesses. When undefined, every access is followed by one IDLE cycle.
//
// Parameters
//   MAX_BURST   maximum back-to-back sequential grants to one requester (1..15)
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   reqN_en/wr/addr/wdata  (in)     requester N command (N = 0, 1)
//   reqN_rdy               (out)    requester N completion pulse
//   reqN_rdata             (out)    read data (always mem_rdata; qualify with rdy)
//   mem_en/wr/addr/wdata   (out)    memory port command
//   mem_rdy, mem_rdata     (in)     memory port completion and read data
module spi_mem_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_en,
  input  logic        req0_wr,
  input  logic [23:0] req0_addr,
  input  logic [7:0]  req0_wdata,
  output logic        req0_rdy,
  output logic [7:0]  req0_rdata,
  input  logic        req1_en,
  input  logic        req1_wr,
  input  logic [23:0] req1_addr,
  input  logic [7:0]  req1_wdata,
  output logic        req1_rdy,
  output logic [7:0]  req1_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [23:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_rdy,
  input  logic [7:0]  mem_rdata
);

  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
    $error("spi_mem_arbiter: MAX_BURST must be in 1..15");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  // r_grant doubles as last_grant: it keeps the most recent winner.
  logic        r_grant;
  logic        w_grant_nxt;
  // Blocks arbitration on the first edge after reset release so the
  // earliest grant lands on the second rising edge.
  logic        r_armed;

  logic        w_gnt_wr;
  logic [23:0] w_gnt_addr;
  logic [7:0]  w_gnt_wdata;

  assign w_gnt_wr    = r_grant ? req1_wr    : req0_wr;
  assign w_gnt_addr  = r_grant ? req1_addr  : req0_addr;
  assign w_gnt_wdata = r_grant ? req1_wdata : req0_wdata;

`ifdef SPI_ARB_BURST_EN
  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST - 1);

  logic [3:0]  r_burst_cnt;
  logic [3:0]  w_burst_cnt_nxt;
  logic [23:0] r_prev_addr;
  logic        r_prev_wr;
  logic        w_gnt_en;
  logic        w_seq;
  logic        w_load_prev;
  logic [23:0] w_nxt_addr;
  logic        w_nxt_wr;

  assign w_gnt_en = r_grant ? req1_en : req0_en;
  // The 24-bit compare width makes FFFFFF -> 000000 count as sequential.
  assign w_seq    = w_gnt_en && (w_gnt_addr == r_prev_addr + 24'd1) &&
                    (w_gnt_wr == r_prev_wr) && (r_burst_cnt < BURST_LIM);

  // Capture the address of every access that starts, whether from IDLE
  // or as a burst continuation, so the next sequential check has a base.
  assign w_load_prev = (w_state_nxt == ST_BUSY) &&
                       ((r_state == ST_IDLE) || mem_rdy);
  assign w_nxt_addr  = w_grant_nxt ? req1_addr : req0_addr;
  assign w_nxt_wr    = w_grant_nxt ? req1_wr   : req0_wr;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= 1'b1;
      r_armed <= 1'b0;
`ifdef SPI_ARB_BURST_EN
      r_burst_cnt <= '0;
      r_prev_addr <= '0;
      r_prev_wr   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_armed <= 1'b1;
`ifdef SPI_ARB_BURST_EN
      r_burst_cnt <= w_burst_cnt_nxt;
      if (w_load_prev) begin
        r_prev_addr <= w_nxt_addr;
        r_prev_wr   <= w_nxt_wr;
      end
`endif
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
`ifdef SPI_ARB_BURST_EN
    w_burst_cnt_nxt = r_burst_cnt;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (r_armed && (req0_en || req1_en)) begin
          // On a tie the requester that was not granted last wins.
          if (req0_en && req1_en) begin
            w_grant_nxt = ~r_grant;
          end else begin
            w_grant_nxt = req1_en;
          end
          w_state_nxt = ST_BUSY;
        end
`ifdef SPI_ARB_BURST_EN
        w_burst_cnt_nxt = '0;
`endif
      end
      ST_BUSY: begin
        if (mem_rdy) begin
`ifdef SPI_ARB_BURST_EN
          if (w_seq) begin
            w_burst_cnt_nxt = r_burst_cnt + 4'd1;
          end else begin
            w_state_nxt     = ST_IDLE;
            w_burst_cnt_nxt = '0;
          end
`else
          w_state_nxt = ST_IDLE;
`endif
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    req0_rdy  = 1'b0;
    req1_rdy  = 1'b0;
    if (r_state == ST_BUSY) begin
      mem_en    = 1'b1;
      mem_wr    = w_gnt_wr;
      mem_addr  = w_gnt_addr;
      mem_wdata = w_gnt_wdata;
      req0_rdy  = mem_rdy & ~r_grant;
      req1_rdy  = mem_rdy &  r_grant;
    end
  end

  assign req0_rdata = mem_rdata;
  assign req1_rdata = mem_rdata;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Testbench for spi_mem_arbiter: table of per-cycle vectors plus hand
// sequences for tie alternation, reset-release delay, mid-access reset
// and sequential bursts (expectations depend on SPI_ARB_BURST_EN).
module tb_spi_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_en, req0_wr, req0_rdy;
  logic [23:0] req0_addr;
  logic [7:0]  req0_wdata, req0_rdata;
  logic        req1_en, req1_wr, req1_rdy;
  logic [23:0] req1_addr;
  logic [7:0]  req1_wdata, req1_rdata;
  logic        mem_en, mem_wr, mem_rdy;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  int unsigned total = 0;
  int unsigned bad   = 0;

  spi_mem_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_en(req0_en), .req0_wr(req0_wr), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_rdy(req0_rdy), .req0_rdata(req0_rdata),
    .req1_en(req1_en), .req1_wr(req1_wr), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_rdy(req1_rdy), .req1_rdata(req1_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en0, wr0;
    logic [23:0] a0;
    logic [7:0]  d0;
    logic        en1, wr1;
    logic [23:0] a1;
    logic [7:0]  d1;
    logic        mrdy;
    logic [7:0]  mrd;
    logic        x_en, x_wr;
    logic [23:0] x_addr;
    logic [7:0]  x_wd;
    logic        x_r0, x_r1;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mk(
    input logic en0, input logic wr0, input logic [23:0] a0, input logic [7:0] d0,
    input logic en1, input logic wr1, input logic [23:0] a1, input logic [7:0] d1,
    input logic mrdy, input logic [7:0] mrd,
    input logic x_en, input logic x_wr, input logic [23:0] x_addr,
    input logic [7:0] x_wd, input logic x_r0, input logic x_r1);
    vec_t v;
    v.en0 = en0; v.wr0 = wr0; v.a0 = a0; v.d0 = d0;
    v.en1 = en1; v.wr1 = wr1; v.a1 = a1; v.d1 = d1;
    v.mrdy = mrdy; v.mrd = mrd;
    v.x_en = x_en; v.x_wr = x_wr; v.x_addr = x_addr; v.x_wd = x_wd;
    v.x_r0 = x_r0; v.x_r1 = x_r1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    req0_en = 0; req0_wr = 0; req0_addr = '0; req0_wdata = '0;
    req1_en = 0; req1_wr = 0; req1_addr = '0; req1_wdata = '0;
    mem_rdy = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for an access, checks its address, completes it with a
  // one-cycle mem_rdy and retires whichever requester got the rdy.
  task automatic serve(input string nm, input logic [23:0] exp_addr);
    int unsigned n = 0;
    logic g0, g1;
    #1;
    while (!mem_en && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({nm, "_en"}, {31'd0, mem_en}, 32'd1);
    chk({nm, "_addr"}, {8'd0, mem_addr}, {8'd0, exp_addr});
    @(negedge clk);
    mem_rdy = 1'b1;
    #1;
    g0 = req0_rdy;
    g1 = req1_rdy;
    chk({nm, "_one_rdy"}, {31'd0, g0 ^ g1}, 32'd1);
    @(negedge clk);
    mem_rdy = 1'b0;
    if (g0) req0_en = 1'b0;
    if (g1) req1_en = 1'b0;
  endtask

  logic [23:0] exp_seq[7];
  bit          exp_ctg[7];
  logic [23:0] got_a[8];
  bit          got_c[8];

  initial begin
    vec_t v;
    // --------------------------------------------------------------
    // Table: one entry per clock cycle, outputs checked #1 after the
    // inputs are applied at the falling edge.
    //          en0 wr0 a0        d0     en1 wr1 a1        d1     rdy mrd    x_en x_wr x_addr    x_wd   r0 r1
    vt[0]  = mk(0, 0, 24'h0,      8'h0,  0, 0, 24'h0,      8'h0,  0, 8'h00,  0, 0, 24'h0,      8'h0,  0, 0);
    vt[1]  = mk(1, 0, 24'h000400, 8'h0,  0, 0, 24'h0,      8'h0,  0, 8'h00,  0, 0, 24'h0,      8'h0,  0, 0);
    vt[2]  = mk(1, 0, 24'h000400, 8'h0,  0, 0, 24'h0,      8'h0,  0, 8'h00,  1, 0, 24'h000400, 8'h0,  0, 0);
    vt[3]  = vt[2];
    vt[4]  = vt[2];
    vt[5]  = vt[2];
    vt[6]  = mk(1, 0, 24'h000400, 8'h0,  0, 0, 24'h0,      8'h0,  1, 8'hA9,  1, 0, 24'h000400, 8'h0,  1, 0);
    vt[7]  = mk(0, 0, 24'h0,      8'h0,  0, 0, 24'h0,      8'h0,  0, 8'h00,  0, 0, 24'h0,      8'h0,  0, 0);
    vt[8]  = mk(0, 0, 24'h0,      8'h0,  0, 0, 24'h0,      8'h0,  1, 8'h33,  0, 0, 24'h0,      8'h0,  0, 0);
    vt[9]  = mk(1, 0, 24'h000100, 8'h0,  1, 1, 24'h000200, 8'h55, 0, 8'h00,  0, 0, 24'h0,      8'h0,  0, 0);
    vt[10] = mk(1, 0, 24'h000100, 8'h0,  1, 1, 24'h000200, 8'h55, 0, 8'h00,  1, 1, 24'h000200, 8'h55, 0, 0);
    vt[11] = mk(1, 0, 24'h000100, 8'h0,  1, 1, 24'h000200, 8'h55, 1, 8'h5A,  1, 1, 24'h000200, 8'h55, 0, 1);
    vt[12] = mk(1, 0, 24'h000100, 8'h0,  0, 0, 24'h0,      8'h0,  0, 8'h00,  0, 0, 24'h0,      8'h0,  0, 0);
    vt[13] = mk(0, 0, 24'h000100, 8'h0,  0, 0, 24'h0,      8'h0,  0, 8'h00,  1, 0, 24'h000100, 8'h0,  0, 0);
    vt[14] = mk(0, 0, 24'h000100, 8'h0,  0, 0, 24'h0,      8'h0,  1, 8'h77,  1, 0, 24'h000100, 8'h0,  1, 0);
    vt[15] = vt[0];

    do_reset();
    #1;
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_rdy0", {31'd0, req0_rdy}, 32'd0);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      v = vt[i];
      req0_en = v.en0; req0_wr = v.wr0; req0_addr = v.a0; req0_wdata = v.d0;
      req1_en = v.en1; req1_wr = v.wr1; req1_addr = v.a1; req1_wdata = v.d1;
      mem_rdy = v.mrdy; mem_rdata = v.mrd;
      #1;
      chk($sformatf("v%0d_mem_en", i), {31'd0, mem_en}, {31'd0, v.x_en});
      chk($sformatf("v%0d_mem_wr", i), {31'd0, mem_wr}, {31'd0, v.x_wr});
      chk($sformatf("v%0d_mem_addr", i), {8'd0, mem_addr}, {8'd0, v.x_addr});
      chk($sformatf("v%0d_mem_wdata", i), {24'd0, mem_wdata}, {24'd0, v.x_wd});
      chk($sformatf("v%0d_rdy0", i), {31'd0, req0_rdy}, {31'd0, v.x_r0});
      chk($sformatf("v%0d_rdy1", i), {31'd0, req1_rdy}, {31'd0, v.x_r1});
      chk($sformatf("v%0d_rdata0", i), {24'd0, req0_rdata}, {24'd0, v.mrd});
      chk($sformatf("v%0d_rdata1", i), {24'd0, req1_rdata}, {24'd0, v.mrd});
      @(negedge clk);
    end

    // --------------------------------------------------------------
    // Tie alternation from reset, plus no grant on the first edge
    // after reset release even with requests already present.
    rst_n = 1'b0;
    clear_inputs();
    req0_en = 1; req0_addr = 24'h000111;
    req1_en = 1; req1_addr = 24'h000222;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("arm_first_edge_en", {31'd0, mem_en}, 32'd0);
    serve("tie1_req0", 24'h000111);
    serve("tie1_req1", 24'h000222);
    req0_en = 1; req1_en = 1;
    serve("tie2_req0", 24'h000111);
    serve("tie2_req1", 24'h000222);

    // --------------------------------------------------------------
    // Reset mid-access: outputs drop asynchronously, and a later stray
    // mem_rdy produces no rdy.
    do_reset();
    @(negedge clk);
    req0_en = 1; req0_addr = 24'h000123;
    repeat (2) @(negedge clk);
    #1;
    chk("midrst_busy", {31'd0, mem_en}, 32'd1);
    #2;
    mem_rdy = 1'b1;
    rst_n   = 1'b0;
    #1;
    chk("midrst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("midrst_rdy0", {31'd0, req0_rdy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req0_en = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      chk("postrst_rdy0", {31'd0, req0_rdy}, 32'd0);
      chk("postrst_rdy1", {31'd0, req1_rdy}, 32'd0);
      chk("postrst_mem_en", {31'd0, mem_en}, 32'd0);
    end
    mem_rdy = 1'b0;

    // --------------------------------------------------------------
    // Sequential reads 0x10..0x15 from req0 with req1 pending. The
    // requester presents its next address in the cycle its rdy fires.
`ifdef SPI_ARB_BURST_EN
    exp_seq = '{24'h10, 24'h11, 24'h12, 24'h13, 24'h300, 24'h14, 24'h15};
    exp_ctg = '{0, 1, 1, 1, 0, 0, 1};
`else
    exp_seq = '{24'h10, 24'h300, 24'h11, 24'h12, 24'h13, 24'h14, 24'h15};
    exp_ctg = '{0, 0, 0, 0, 0, 0, 0};
`endif
    do_reset();
    @(negedge clk);
    begin
      int unsigned k = 0, ng = 0, lat = 0, cyc = 0;
      bit done1 = 0, prev_en = 0, prev_rdy = 0;
      req0_en = 1; req0_addr = 24'h000010;
      req1_en = 1; req1_addr = 24'h000300;
      while (!(k == 6 && done1) && cyc < 200) begin
        @(negedge clk);
        mem_rdy = 1'b0;
        #1;
        cyc++;
        if (mem_en && (!prev_en || prev_rdy)) begin
          if (ng < 8) begin
            got_a[ng] = mem_addr;
            got_c[ng] = prev_en;
          end
          ng++;
          lat = 0;
        end
        if (mem_en) begin
          lat++;
          if (lat == 2) begin
            mem_rdy = 1'b1;
            #1;
            if (req0_rdy) begin
              k++;
              if (k < 6) req0_addr = 24'h000010 + 24'(k);
              else       req0_en   = 1'b0;
            end
            if (req1_rdy) begin
              req1_en = 1'b0;
              done1   = 1;
            end
            lat = 0;
          end
        end
        prev_en  = mem_en;
        prev_rdy = mem_rdy;
      end
      @(negedge clk);
      mem_rdy = 1'b0;
      chk("burst_complete", {31'd0, (k == 6 && done1)}, 32'd1);
      chk("burst_count", ng, 32'd7);
      for (int i = 0; i < 7; i++) begin
        chk($sformatf("burst_addr%0d", i), {8'd0, got_a[i]}, {8'd0, exp_seq[i]});
        chk($sformatf("burst_contig%0d", i), {31'd0, got_c[i]}, {31'd0, exp_ctg[i]});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
